// File: rtl/dmem_latency_pkg.sv
// Shared types and constants for the dmem_latency_model slice.
// Also holds the LFSR constants that are used only when DMEM_LAT_JITTER_EN is defined.
package dmem_latency_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int          JITTER_W  = 2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lat_jitter_lfsr.sv
// 16-bit Fibonacci LFSR that supplies 2 bits of latency jitter per accepted request.
// It is instantiated by dmem_latency_model only when DMEM_LAT_JITTER_EN is defined.
module lat_jitter_lfsr
  import dmem_latency_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                i_en,
  output logic [JITTER_W-1:0] o_jitter
);

  logic [15:0] r_lfsr;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
    end
  end

  // The current value is used by the request being accepted; the register then steps on.
  assign o_jitter = r_lfsr[JITTER_W-1:0];

endmodule

// File: rtl/dmem_latency_model.sv
// Data memory with a programmable wait-state latency, a READY handshake, range error and stall counter.
// Optional macro DMEM_LAT_JITTER_EN adds 0..3 cycles of LFSR jitter to every access.
module dmem_latency_model
  import dmem_latency_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int SIZE     = 4096,
  parameter int LWIDTH   = 3,
  parameter int MAX_LAT  = 7,
  parameter     INITFILE = ""
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                CSN,
  input  logic                WEN,
  input  logic [AWIDTH-1:0]   ADDR,
  input  logic [DWIDTH-1:0]   DI,
  input  logic [DWIDTH/8-1:0] BE,
  input  logic [LWIDTH-1:0]   LATENCY,
  output logic [DWIDTH-1:0]   DOUT,
  output logic                READY,
  output logic                ERR,
  output logic [31:0]         STALL_CNT
);

  localparam int NB = DWIDTH / 8;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AWIDTH:0]   SIZE_A    = (AWIDTH + 1)'(SIZE);
  localparam logic [LWIDTH-1:0] MAX_LAT_L = LWIDTH'(MAX_LAT);
`ifdef DMEM_LAT_JITTER_EN
  localparam int JW = JITTER_W;
`else
  localparam int JW = 0;
`endif
  localparam int CW = LWIDTH + JW;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_lat;
  logic [LWIDTH-1:0]   w_lat_clamp;
  logic                r_wen;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_di;
  logic [NB-1:0]       r_be;
  logic                r_ready;
  logic                r_err;
  logic [DWIDTH-1:0]   r_dout;
  logic [31:0]         r_stall_cnt;
  logic                w_accept;
  logic                w_complete;
  logic                w_from_regs;
  logic                w_acc_wen;
  logic [AWIDTH-1:0]   w_acc_addr;
  logic [DWIDTH-1:0]   w_acc_di;
  logic [NB-1:0]       w_acc_be;
  logic [IW-1:0]       w_idx;
  logic                w_in_range;
  logic                w_wr_en;
  logic [DWIDTH-1:0]   r_mem [SIZE];

  // Preloading from INITFILE is done hierarchically into r_mem by the wrapper.
  if (INITFILE != "") begin : g_initfile
  end

  assign w_lat_clamp = (LATENCY > MAX_LAT_L) ? MAX_LAT_L : LATENCY;

`ifdef DMEM_LAT_JITTER_EN
  logic [JITTER_W-1:0] w_jitter;

  lat_jitter_lfsr u_jitter (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_en     (w_accept),
    .o_jitter (w_jitter)
  );

  assign w_lat = CW'(w_lat_clamp) + CW'(w_jitter);
`else
  assign w_lat = w_lat_clamp;
`endif

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!CSN) begin
          w_accept = 1'b1;
          if (w_lat == '0) begin
            w_complete = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_count == CW'(1)) begin
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Zero-latency accesses act on the live inputs; delayed ones on the values latched at acceptance.
  assign w_from_regs = (r_state == WAIT);
  assign w_acc_wen   = w_from_regs ? r_wen  : WEN;
  assign w_acc_addr  = w_from_regs ? r_addr : ADDR;
  assign w_acc_di    = w_from_regs ? r_di   : DI;
  assign w_acc_be    = w_from_regs ? r_be   : BE;
  assign w_idx       = w_acc_addr[IW-1:0];
  assign w_in_range  = ({1'b0, w_acc_addr} < SIZE_A);
  assign w_wr_en     = RSTn && w_complete && !w_acc_wen && w_in_range;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_ready     <= 1'b1;
      r_dout      <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_complete && !w_in_range;
      if (!r_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_accept) begin
        r_count <= w_lat;
        r_ready <= (w_lat == '0);
      end else if (r_state == WAIT) begin
        r_count <= r_count - CW'(1);
        if (w_complete) begin
          r_ready <= 1'b1;
        end
      end
      if (w_complete && w_acc_wen) begin
        r_dout <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_wen  <= WEN;
      r_addr <= ADDR;
      r_di   <= DI;
      r_be   <= BE;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (w_acc_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_acc_di[8*b +: 8];
        end
      end
    end
  end

  assign DOUT      = r_dout;
  assign READY     = r_ready;
  assign ERR       = r_err;
  assign STALL_CNT = r_stall_cnt;

endmodule
